// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard front end:
//   - scan-code constants for the E0/F0 prefixes and the four arrow keys
//   - receive-frame FSM state type
//   - packed arrow-flag record used by the optional held arrow outputs
//   - is_prefix() helper used by the key decoder
// ----------------------------------------------------------------------------
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_UP    = 8'h75;
  localparam logic [7:0] PS2_DOWN  = 8'h72;
  localparam logic [7:0] PS2_LEFT  = 8'h6B;
  localparam logic [7:0] PS2_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } arrow_flags_t;

  // E0 and F0 only modify the following byte; they are never events.
  function automatic logic is_prefix(input logic [7:0] code);
    return (code == PS2_EXT) || (code == PS2_BRK);
  endfunction

endpackage : ps2_pkg

// File: rtl/ps2_rx_frame.sv
// ----------------------------------------------------------------------------
// ps2_rx_frame
// Receives 11-bit device-to-host PS/2 frames (start, 8 data LSB-first, odd
// parity, stop). Both raw pins are synchronised and glitch-filtered; the
// falling edge of the filtered clock is the only sample event.
//
// Ports:
//   CLK100MHz   in   system clock
//   reset       in   synchronous, active-high reset
//   ps2_clk_i   in   raw PS/2 clock pin (asynchronous)
//   ps2_data_i  in   raw PS/2 data pin (asynchronous)
//   byte_rdy_o  out  one-cycle pulse: byte_o holds a correctly framed byte
//   byte_o      out  last shifted-in data byte
//   err_o       out  one-cycle pulse: parity/stop error or in-frame timeout
//
// byte_rdy_o and err_o are combinational in the STOP-sample cycle so the
// consumer's output register lands exactly one cycle after that sample.
// ----------------------------------------------------------------------------
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       CLK100MHz,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_rdy_o,
  output logic [7:0] byte_o,
  output logic       err_o
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FCW-1:0] FILT_MAX = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] TMO_MAX  = TCW'(TIMEOUT_CYCLES - 1);

  // index 0 = clock line, index 1 = data line
  logic [1:0] raw_pins;
  logic [1:0] filt;

  assign raw_pins = {ps2_data_i, ps2_clk_i};

  // --------------------------------------------------------------------------
  // Synchroniser + stability filter per line. The filtered value only moves
  // after FILTER_LEN consecutive synchronised samples disagree with it; any
  // agreeing sample reloads the counter, so short glitches are discarded.
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : g_filt
    logic           sync1_q;
    logic           sync2_q;
    logic           filt_q;
    logic [FCW-1:0] cnt_q;

    // NOTE: clocked state is always assigned with <= so every flop samples
    // the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge CLK100MHz) begin
      if (reset) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        filt_q  <= 1'b1;
        cnt_q   <= '0;
      end else begin
        sync1_q <= raw_pins[g];
        sync2_q <= sync1_q;
        if (sync2_q == filt_q) begin
          cnt_q <= '0;
        end else if (cnt_q == FILT_MAX) begin
          filt_q <= sync2_q;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign filt[g] = filt_q;
  end

  // --------------------------------------------------------------------------
  // Falling-edge detect on the filtered clock
  // --------------------------------------------------------------------------
  logic clk_prev_q;
  logic sample;
  logic data_f;

  always_ff @(posedge CLK100MHz) begin
    if (reset) clk_prev_q <= 1'b1;
    else       clk_prev_q <= filt[0];
  end

  assign sample = clk_prev_q & ~filt[0];
  assign data_f = filt[1];

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  rx_state_e      state_q,   state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q,   shift_d;
  logic           parity_q,  parity_d;
  logic [TCW-1:0] tmo_q,     tmo_d;

  always_ff @(posedge CLK100MHz) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    byte_rdy_o = 1'b0;
    err_o      = 1'b0;

    // Idle time is only measured while a frame is open.
    if (sample || (state_q == IDLE)) tmo_d = '0;
    else                             tmo_d = tmo_q + 1'b1;

    if (sample) begin
      unique case (state_q)
        IDLE: begin
          if (!data_f) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {data_f, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_d = data_f;
          state_d  = STOP;
        end
        STOP: begin
          // Odd parity over data+parity, and stop must be high.
          if (data_f && ((^shift_q) ^ parity_q)) byte_rdy_o = 1'b1;
          else                                   err_o      = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if ((state_q != IDLE) && (tmo_q == TMO_MAX)) begin
      state_d = IDLE;
      err_o   = 1'b1;
    end
  end

  assign byte_o = shift_q;

endmodule : ps2_rx_frame

// File: rtl/ps2_key_decoder.sv
// ----------------------------------------------------------------------------
// ps2_key_decoder
// PS/2 keyboard front end: receives frames via ps2_rx_frame and folds the
// E0 (extended) / F0 (break) prefix bytes into single key events.
//
// Ports:
//   CLK100MHz    in   system clock
//   reset        in   synchronous, active-high reset
//   ps2_clk      in   raw PS/2 clock pin
//   ps2_data     in   raw PS/2 data pin
//   key_valid    out  one-cycle pulse per complete key event
//   key_code     out  final scan byte of the event (held)
//   key_ext      out  event was E0-prefixed (held)
//   key_release  out  event was F0-prefixed (held)
//   frame_err    out  one-cycle pulse on parity/stop error or timeout
//   arrow_up/down/left/right  out  held key-down flags for the extended
//                                  arrow keys; present only when the macro
//                                  PS2_ARROW_FLAGS_EN is defined
// ----------------------------------------------------------------------------
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       CLK100MHz,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       frame_err
`ifdef PS2_ARROW_FLAGS_EN
  ,
  output logic       arrow_up,
  output logic       arrow_down,
  output logic       arrow_left,
  output logic       arrow_right
`endif
);

  logic       rx_rdy;
  logic [7:0] rx_byte;
  logic       rx_err;

  ps2_rx_frame #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .CLK100MHz  (CLK100MHz),
    .reset      (reset),
    .ps2_clk_i  (ps2_clk),
    .ps2_data_i (ps2_data),
    .byte_rdy_o (rx_rdy),
    .byte_o     (rx_byte),
    .err_o      (rx_err)
  );

  // --------------------------------------------------------------------------
  // Prefix decode and output registers
  // --------------------------------------------------------------------------
  logic       key_valid_q,   key_valid_d;
  logic       frame_err_q,   frame_err_d;
  logic [7:0] key_code_q,    key_code_d;
  logic       key_ext_q,     key_ext_d;
  logic       key_release_q, key_release_d;
  logic       ext_pend_q,    ext_pend_d;
  logic       rel_pend_q,    rel_pend_d;

  always_ff @(posedge CLK100MHz) begin
    if (reset) begin
      key_valid_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      key_code_q    <= 8'h00;
      key_ext_q     <= 1'b0;
      key_release_q <= 1'b0;
      ext_pend_q    <= 1'b0;
      rel_pend_q    <= 1'b0;
    end else begin
      key_valid_q   <= key_valid_d;
      frame_err_q   <= frame_err_d;
      key_code_q    <= key_code_d;
      key_ext_q     <= key_ext_d;
      key_release_q <= key_release_d;
      ext_pend_q    <= ext_pend_d;
      rel_pend_q    <= rel_pend_d;
    end
  end

  always_comb begin
    key_valid_d   = 1'b0;
    frame_err_d   = rx_err;
    key_code_d    = key_code_q;
    key_ext_d     = key_ext_q;
    key_release_d = key_release_q;
    ext_pend_d    = ext_pend_q;
    rel_pend_d    = rel_pend_q;

    // rx_err and rx_rdy are mutually exclusive, so the two pulses never
    // coincide. An error discards any half-received prefix sequence.
    if (rx_err) begin
      ext_pend_d = 1'b0;
      rel_pend_d = 1'b0;
    end else if (rx_rdy) begin
      if (rx_byte == PS2_EXT) begin
        ext_pend_d = 1'b1;
      end else if (rx_byte == PS2_BRK) begin
        rel_pend_d = 1'b1;
      end else begin
        key_valid_d   = 1'b1;
        key_code_d    = rx_byte;
        key_ext_d     = ext_pend_q;
        key_release_d = rel_pend_q;
        ext_pend_d    = 1'b0;
        rel_pend_d    = 1'b0;
      end
    end
  end

  assign key_valid   = key_valid_q;
  assign frame_err   = frame_err_q;
  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_release = key_release_q;

`ifdef PS2_ARROW_FLAGS_EN
  // --------------------------------------------------------------------------
  // Held arrow flags: updated on the same edge that raises key_valid, using
  // the pending prefix state the event is built from. Repeated makes simply
  // rewrite a 1.
  // --------------------------------------------------------------------------
  arrow_flags_t arrows_q, arrows_d;

  always_ff @(posedge CLK100MHz) begin
    if (reset) arrows_q <= '0;
    else       arrows_q <= arrows_d;
  end

  always_comb begin
    arrows_d = arrows_q;
    if (rx_rdy && !rx_err && !is_prefix(rx_byte) && ext_pend_q) begin
      unique case (rx_byte)
        PS2_UP:    arrows_d.up    = ~rel_pend_q;
        PS2_DOWN:  arrows_d.down  = ~rel_pend_q;
        PS2_LEFT:  arrows_d.left  = ~rel_pend_q;
        PS2_RIGHT: arrows_d.right = ~rel_pend_q;
        default:   arrows_d = arrows_q;
      endcase
    end
  end

  assign arrow_up    = arrows_q.up;
  assign arrow_down  = arrows_q.down;
  assign arrow_left  = arrows_q.left;
  assign arrow_right = arrows_q.right;
`endif

endmodule : ps2_key_decoder

// File: tb/tb_ps2_key_decoder.sv
// ----------------------------------------------------------------------------
// tb_ps2_key_decoder
// Drives PS/2 frames (directed and randomized, with optional glitches, bad
// parity/stop, stalled frames and mid-frame reset) and compares the decoder
// against a byte-level reference model of the prefix/event rules.
// ----------------------------------------------------------------------------
module tb_ps2_key_decoder;

  localparam int FILTER_LEN = 8;
  localparam int TMO        = 3000;

  logic       CLK100MHz = 1'b0;
  logic       reset     = 1'b1;
  logic       ps2_clk   = 1'b1;
  logic       ps2_data  = 1'b1;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       frame_err;
`ifdef PS2_ARROW_FLAGS_EN
  logic       arrow_up, arrow_down, arrow_left, arrow_right;
`endif

  always #5 CLK100MHz = ~CLK100MHz;

  ps2_key_decoder #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK100MHz   (CLK100MHz),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_release (key_release),
    .frame_err   (frame_err)
`ifdef PS2_ARROW_FLAGS_EN
    ,
    .arrow_up    (arrow_up),
    .arrow_down  (arrow_down),
    .arrow_left  (arrow_left),
    .arrow_right (arrow_right)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- pulse monitor (samples on the falling clock edge) -------
  int   kv_seen = 0, fe_seen = 0, overlap = 0, wide = 0;
  logic kv_prev = 1'b0, fe_prev = 1'b0;

  always @(negedge CLK100MHz) begin
    if (key_valid === 1'b1) kv_seen++;
    if (frame_err === 1'b1) fe_seen++;
    if (key_valid === 1'b1 && frame_err === 1'b1) overlap++;
    if ((key_valid === 1'b1 && kv_prev) || (frame_err === 1'b1 && fe_prev)) wide++;
    kv_prev = (key_valid === 1'b1);
    fe_prev = (frame_err === 1'b1);
  end

  // ---------------- reference model state ---------------------------------
  logic       m_ext = 0, m_rel = 0;
  logic [7:0] m_code = 8'h00;
  logic       m_kext = 0, m_krel = 0;
  logic       m_up = 0, m_down = 0, m_left = 0, m_right = 0;

  task automatic model_reset();
    m_ext = 0; m_rel = 0; m_code = 8'h00; m_kext = 0; m_krel = 0;
    m_up = 0; m_down = 0; m_left = 0; m_right = 0;
  endtask

  // Waits n clocks and leaves the caller 2 time units past the rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge CLK100MHz);
    #2;
  endtask

  // One PS/2 bit: data set while clock high, then a low and a high phase.
  task automatic drive_bit(input logic b, input logic glitch, input int hp);
    ps2_data = b;
    if (glitch) begin
      cyc(3); ps2_clk = 1'b0; cyc(3); ps2_clk = 1'b1; cyc(hp - 6);
    end else begin
      cyc(hp);
    end
    ps2_clk = 1'b0;
    if (glitch) begin
      cyc(3); ps2_data = ~b; cyc(3); ps2_data = b; cyc(hp - 6);
    end else begin
      cyc(hp);
    end
    ps2_clk = 1'b1;
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop
  task automatic send_frame(input logic [7:0] b, input int kind, input logic glitch);
    logic [10:0] bits;
    int hp;
    hp = $urandom_range(16, 22);
    bits[0]   = 1'b0;
    bits[8:1] = b;
    bits[9]   = ~(^b) ^ (kind == 1);
    bits[10]  = (kind == 2) ? 1'b0 : 1'b1;
    for (int i = 0; i < 11; i++) drive_bit(bits[i], glitch, hp);
    ps2_data = 1'b1;
    cyc(30);
  endtask

  task automatic check_held(input string tag);
    check({tag, ".code"}, key_code, m_code);
    check({tag, ".ext"},  key_ext,  m_kext);
    check({tag, ".rel"},  key_release, m_krel);
`ifdef PS2_ARROW_FLAGS_EN
    check({tag, ".arrows"}, {arrow_up, arrow_down, arrow_left, arrow_right},
          {m_up, m_down, m_left, m_right});
`endif
  endtask

  // Sends one byte and checks pulses and held outputs against the model.
  task automatic send_check(input string tag, input logic [7:0] b, input int kind,
                            input logic glitch);
    int kv0, fe0, exp_kv, exp_fe;
    kv0 = kv_seen; fe0 = fe_seen;
    send_frame(b, kind, glitch);
    exp_kv = 0; exp_fe = 0;
    if (kind != 0) begin
      exp_fe = 1; m_ext = 0; m_rel = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_rel = 1;
    end else begin
      exp_kv = 1; m_code = b; m_kext = m_ext; m_krel = m_rel;
      if (m_ext) begin
        if (b == 8'h75) m_up    = !m_rel;
        if (b == 8'h72) m_down  = !m_rel;
        if (b == 8'h6B) m_left  = !m_rel;
        if (b == 8'h74) m_right = !m_rel;
      end
      m_ext = 0; m_rel = 0;
    end
    check({tag, ".kv_pulses"}, kv_seen - kv0, exp_kv);
    check({tag, ".err_pulses"}, fe_seen - fe0, exp_fe);
    check_held(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".kv"},   key_valid, 0);
    check({tag, ".fe"},   frame_err, 0);
    check({tag, ".code"}, key_code, 8'h00);
    check({tag, ".ext"},  key_ext, 0);
    check({tag, ".rel"},  key_release, 0);
`ifdef PS2_ARROW_FLAGS_EN
    check({tag, ".arrows"}, {arrow_up, arrow_down, arrow_left, arrow_right}, 4'b0000);
`endif
  endtask

  logic [7:0] arrows_tbl [4];
  int kv0, fe0;

  initial begin
    arrows_tbl[0] = 8'h75; arrows_tbl[1] = 8'h72;
    arrows_tbl[2] = 8'h6B; arrows_tbl[3] = 8'h74;

    reset = 1'b1;
    cyc(5);
    check_reset_values("reset");
    reset = 1'b0;
    cyc(5);

    // Directed sequences
    send_check("plain_1C", 8'h1C, 0, 0);
    send_check("ext_E0",   8'hE0, 0, 0);
    send_check("ext_75",   8'h75, 0, 0);
    send_check("rep_E0",   8'hE0, 0, 0);
    send_check("rep_75",   8'h75, 0, 0);
    send_check("brk_E0",   8'hE0, 0, 0);
    send_check("brk_F0",   8'hF0, 0, 0);
    send_check("brk_75",   8'h75, 0, 0);
    send_check("par_bad",  8'h1C, 1, 0);
    send_check("par_good", 8'h1C, 0, 0);
    send_check("stop_bad", 8'h1C, 2, 0);
    send_check("stop_good", 8'h1C, 0, 0);
    send_check("e1_code",  8'hE1, 0, 0);

    // Stalled frame with a pending E0: timeout must abort and drop the prefix
    send_check("tmo_E0", 8'hE0, 0, 0);
    kv0 = kv_seen; fe0 = fe_seen;
    drive_bit(1'b0, 1'b0, 18);
    drive_bit(1'b1, 1'b0, 18);
    drive_bit(1'b0, 1'b0, 18);
    drive_bit(1'b1, 1'b0, 18);
    ps2_data = 1'b1;
    cyc(TMO + 500);
    m_ext = 0; m_rel = 0;
    check("tmo.err_pulses", fe_seen - fe0, 1);
    check("tmo.kv_pulses",  kv_seen - kv0, 0);
    send_check("after_tmo_29", 8'h29, 0, 0);

    // Glitched frames decode without bit slip
    send_check("glitch_E0", 8'hE0, 0, 1);
    send_check("glitch_6B", 8'h6B, 0, 1);
    send_check("glitch_A5", 8'hA5, 0, 1);

    // Reset mid-frame with E0 pending; remaining bits are all ones
    send_check("rst_E0", 8'hE0, 0, 0);
    kv0 = kv_seen; fe0 = fe_seen;
    drive_bit(1'b0, 1'b0, 18);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0, 18);
    reset = 1'b1;
    cyc(3);
    check_reset_values("midrst");
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 7; i++) drive_bit(1'b1, 1'b0, 18);
    cyc(30);
    check("midrst.kv_pulses",  kv_seen - kv0, 0);
    check("midrst.err_pulses", fe_seen - fe0, 0);
    check_held("midrst.after");
    send_check("after_rst_1C", 8'h1C, 0, 0);

    // Randomized key sequences with occasional errors and glitches
    for (int it = 0; it < 25; it++) begin
      logic [7:0] fin;
      int k;
      if ($urandom_range(0, 3) < 2) fin = arrows_tbl[$urandom_range(0, 3)];
      else                          fin = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        k = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 2)) : 0;
        send_check("rnd_E0", 8'hE0, k, ($urandom_range(0, 3) == 0));
      end
      if ($urandom_range(0, 2) == 0) begin
        k = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 2)) : 0;
        send_check("rnd_F0", 8'hF0, k, ($urandom_range(0, 3) == 0));
      end
      k = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 2)) : 0;
      send_check("rnd_key", fin, k, ($urandom_range(0, 3) == 0));
    end

    check("pulse_overlap", overlap, 0);
    check("pulse_width",   wide, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ps2_key_decoder
